// File: rtl/cordic_sched_pkg.sv
// Shared constants for the CORDIC scheduler: c_op encodings, default pipeline latency,
// and a ceil(log2) usable in parameter and port-width expressions.
package cordic_sched_pkg;

   localparam logic [1:0] OP_P2R = 2'd0;
   localparam logic [1:0] OP_R2P = 2'd1;
   localparam int LAT_DEFAULT = 21;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/cordic_sched_rr_grant.sv
// Round-robin picker: first asserted request searching upward from ptr+1, wrapping modulo nch.
// Purely combinational; zero grant when no request is asserted.
module rr_grant import cordic_sched_pkg::*; #(
   parameter int nch = 4
) (
   input  logic [nch-1:0]         req,
   input  logic [clog2(nch)-1:0]  ptr,
   output logic [nch-1:0]         gnt,
   output logic [clog2(nch)-1:0]  idx
);

   localparam int chw = clog2(nch);

   logic [chw-1:0] cand;
   logic           found;

   // nch is a power of two, so the index sum wraps naturally; k == nch lands back on ptr
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = 1; k <= nch; k++) begin
         cand = ptr + chw'(k);
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

// File: rtl/cordic_sched.sv
// Round-robin front end for a pipelined CORDIC with channel tagging and a result FIFO.
// Request-to-result >= lat+2 cycles; issue is credit-limited so the FIFO never overflows.
module cordic_sched import cordic_sched_pkg::*; #(
   parameter int width  = 19,
   parameter int nch    = 4,
   parameter int lat    = LAT_DEFAULT,
   parameter int fdepth = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [nch-1:0]             req_valid,
   output logic [nch-1:0]             req_ready,
   input  logic [nch-1:0]             req_op,
   input  logic [width*nch-1:0]       req_x,
   input  logic [width*nch-1:0]       req_y,
   input  logic [(width+1)*nch-1:0]   req_phase,
   output logic [1:0]                 c_op,
   output logic [width-1:0]           c_x,
   output logic [width-1:0]           c_y,
   output logic [width:0]             c_phase,
   input  logic [width-1:0]           c_xout,
   input  logic [width-1:0]           c_yout,
   input  logic [width:0]             c_phaseout,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [clog2(nch)-1:0]      res_ch,
   output logic [width-1:0]           res_x,
   output logic [width-1:0]           res_y,
   output logic [width:0]             res_phase
);

   localparam int chw = clog2(nch);
   localparam int aw  = clog2(fdepth);
   localparam int cw  = aw + 1;

   typedef struct packed {
      logic [chw-1:0]   ch;
      logic [width-1:0] x;
      logic [width-1:0] y;
      logic [width:0]   ph;
   } res_t;

   logic [cw-1:0]  cred;
   logic [chw-1:0] ptr;
   logic [nch-1:0] elig;
   logic [nch-1:0] gnt;
   logic [chw-1:0] gidx;
   logic           grant;
   logic           pop;

   assign elig      = (cred != '0) ? req_valid : '0;
   assign req_ready = gnt;
   assign grant     = |gnt;
   assign pop       = res_valid & res_ready;

   rr_grant #(.nch(nch)) u_arb (
      .req (elig),
      .ptr (ptr),
      .gnt (gnt),
      .idx (gidx)
   );

   // one credit per FIFO slot; held by an op from grant until its result is popped
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cred <= cw'(fdepth);
         ptr  <= '0;
      end else begin
         if (grant) ptr <= gidx;
         case ({grant, pop})
            2'b10:   cred <= cred - cw'(1);
            2'b01:   cred <= cred + cw'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c_op    <= OP_P2R;
         c_x     <= '0;
         c_y     <= '0;
         c_phase <= '0;
      end else if (grant) begin
         c_op    <= req_op[gidx] ? OP_R2P : OP_P2R;
         c_x     <= req_x[gidx*width +: width];
         c_y     <= req_y[gidx*width +: width];
         c_phase <= req_phase[gidx*(width+1) +: width+1];
      end else begin
         c_op    <= OP_P2R;
         c_x     <= '0;
         c_y     <= '0;
         c_phase <= '0;
      end
   end

   // tag stage lat lines up with the CORDIC output of the op issued lat+1 cycles earlier
   logic [lat:0]   tag_v;
   logic [chw-1:0] tag_ch [lat+1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) tag_v <= '0;
      else     tag_v <= {tag_v[lat-1:0], grant};
   end

   always_ff @(posedge clk) begin
      tag_ch[0] <= gidx;
      for (int i = 1; i <= lat; i++) tag_ch[i] <= tag_ch[i-1];
   end

   logic wr;
   res_t wdat;
   res_t head;

   assign wr   = tag_v[lat];
   assign wdat = {tag_ch[lat], c_xout, c_yout, c_phaseout};

   res_t          mem [fdepth];
   logic [aw-1:0] wp;
   logic [aw-1:0] rp;
   logic [cw-1:0] cnt;
   logic          load;
   logic          bypass;
   logic          mem_wr;
   logic          mem_rd;

   // head register is the FIFO output; mem holds everything queued behind it
   assign load   = !res_valid || pop;
   assign bypass = wr && load && (cnt == '0);
   assign mem_wr = wr && !bypass;
   assign mem_rd = load && (cnt != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp        <= '0;
         rp        <= '0;
         cnt       <= '0;
         res_valid <= 1'b0;
         head      <= '0;
      end else begin
         if (mem_wr) wp <= wp + aw'(1);
         if (load) begin
            if (mem_rd) begin
               head      <= mem[rp];
               rp        <= rp + aw'(1);
               res_valid <= 1'b1;
            end else if (wr) begin
               head      <= wdat;
               res_valid <= 1'b1;
            end else begin
               res_valid <= 1'b0;
            end
         end
         case ({mem_wr, mem_rd})
            2'b10:   cnt <= cnt + cw'(1);
            2'b01:   cnt <= cnt - cw'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (mem_wr) mem[wp] <= wdat;
   end

   assign res_ch    = head.ch;
   assign res_x     = head.x;
   assign res_y     = head.y;
   assign res_phase = head.ph;

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      mem_wr |-> (cnt < cw'(fdepth)));

endmodule

// File: tb/tb_cordic_sched.sv
// Randomized bench for cordic_sched with a stand-in CORDIC pipeline and a queue-based reference.
module tb_cordic_sched;

   localparam int W = 19, N = 4, LAT = 21, FD = 32, CHW = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [N-1:0]     req_valid = '0;
   logic [N-1:0]     req_ready;
   logic [N-1:0]     req_op = '0;
   logic [W*N-1:0]   req_x = '0;
   logic [W*N-1:0]   req_y = '0;
   logic [(W+1)*N-1:0] req_phase = '0;
   logic [1:0]       c_op;
   logic [W-1:0]     c_x, c_y, c_xout, c_yout;
   logic [W:0]       c_phase, c_phaseout;
   logic             res_valid;
   logic             res_ready = 1'b0;
   logic [CHW-1:0]   res_ch;
   logic [W-1:0]     res_x, res_y;
   logic [W:0]       res_phase;

   always #5 clk = ~clk;

   cordic_sched #(.width(W), .nch(N), .lat(LAT), .fdepth(FD)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_x(req_x), .req_y(req_y), .req_phase(req_phase),
      .c_op(c_op), .c_x(c_x), .c_y(c_y), .c_phase(c_phase),
      .c_xout(c_xout), .c_yout(c_yout), .c_phaseout(c_phaseout),
      .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch),
      .res_x(res_x), .res_y(res_y), .res_phase(res_phase)
   );

   typedef struct packed {
      logic         op;
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic [W:0]   ph;
   } opnd_t;

   // stand-in CORDIC transfer function: easy to predict, touches every bit of every operand
   function automatic opnd_t cfun(input opnd_t a);
      opnd_t r;
      r.op = a.op;
      r.x  = a.x + W'(1);
      r.y  = a.y ^ {W{a.op}};
      r.ph = a.ph + (W+1)'(5);
      return r;
   endfunction

   opnd_t pipe [LAT];
   opnd_t cout;

   always @(posedge clk) begin
      pipe[0] <= '{op: c_op[0], x: c_x, y: c_y, ph: c_phase};
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end

   assign cout       = cfun(pipe[LAT-1]);
   assign c_xout     = cout.x;
   assign c_yout     = cout.y;
   assign c_phaseout = cout.ph;

   typedef struct {
      int     ch;
      opnd_t  r;
      longint avail;
   } exp_t;

   exp_t   q[$];
   int     glog[$];
   int     gcnt[N];
   int     m_ptr = 0, m_out = 0, ngrant = 0;
   longint cyc = 0;
   int     total = 0, bad = 0;
   opnd_t  m_c = '0;
   int     eo[4] = '{1, 2, 3, 0};

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // reference: grant = first valid channel above the last grant while fewer than FD ops are
   // unretired; each result becomes visible LAT+2 cycles after its grant, in grant order
   always @(negedge clk) begin
      int          g;
      logic [N-1:0] er;
      logic        ev;
      opnd_t       rq;
      if (rst) begin
         check("rst_req_ready", req_ready, 0);
         check("rst_c_op", c_op, 0);
         check("rst_c_x", c_x, 0);
         check("rst_c_y", c_y, 0);
         check("rst_c_phase", c_phase, 0);
         check("rst_res_valid", res_valid, 0);
         check("rst_res_ch", res_ch, 0);
         check("rst_res_x", res_x, 0);
         check("rst_res_y", res_y, 0);
         check("rst_res_phase", res_phase, 0);
         m_ptr = 0;
         m_out = 0;
         q.delete();
         m_c = '0;
      end else begin
         g = -1;
         if (m_out < FD)
            for (int k = 1; k <= N; k++)
               if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
         er = '0;
         if (g >= 0) er[g] = 1'b1;
         check("req_ready", req_ready, er);
         check("c_op", c_op, {1'b0, m_c.op});
         check("c_x", c_x, m_c.x);
         check("c_y", c_y, m_c.y);
         check("c_phase", c_phase, m_c.ph);
         ev = (q.size() > 0) && (q[0].avail <= cyc);
         check("res_valid", res_valid, ev);
         if (ev) begin
            check("res_ch", res_ch, q[0].ch);
            check("res_x", res_x, q[0].r.x);
            check("res_y", res_y, q[0].r.y);
            check("res_phase", res_phase, q[0].r.ph);
            if (res_ready) begin
               void'(q.pop_front());
               m_out--;
            end
         end
         if (g >= 0) begin
            rq = '{op: req_op[g], x: req_x[g*W +: W], y: req_y[g*W +: W],
                   ph: req_phase[g*(W+1) +: W+1]};
            m_c = rq;
            q.push_back('{ch: g, r: cfun(rq), avail: cyc + LAT + 2});
            m_ptr = g;
            m_out++;
            gcnt[g]++;
            glog.push_back(g);
            ngrant++;
         end else begin
            m_c = '0;
         end
      end
      cyc++;
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      res_ready = 1'b0;
      tick(3);
      rst = 1'b0;
      for (int i = 0; i < N; i++) gcnt[i] = 0;
      glog.delete();
      ngrant = 0;
   endtask

   task automatic rand_data();
      req_op    = N'($urandom());
      req_x     = (W*N)'({$urandom(), $urandom(), $urandom()});
      req_y     = (W*N)'({$urandom(), $urandom(), $urandom()});
      req_phase = ((W+1)*N)'({$urandom(), $urandom(), $urandom()});
   endtask

   initial begin
      int t0, t1, npulse, seen, budget;
      logic [CHW-1:0] cap_ch;
      logic [W-1:0]   cap_x, cap_y;
      logic [W:0]     cap_ph;

      do_reset();
      check("cred_reset", dut.cred, 32);

      // single rect-to-polar request on channel 2
      req_x = '0; req_y = '0; req_phase = '0;
      req_x[2*W +: W] = W'(1000);
      req_op = 4'b0100;
      req_valid = 4'b0100;
      res_ready = 1'b1;
      t0 = -1; t1 = -1; npulse = 0;
      cap_ch = '0; cap_x = '0; cap_y = '0; cap_ph = '0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (req_ready[2]) begin
            npulse++;
            if (t0 < 0) t0 = i;
         end
         if (res_valid && t1 < 0) begin
            t1 = i;
            cap_ch = res_ch; cap_x = res_x; cap_y = res_y; cap_ph = res_phase;
         end
         @(posedge clk);
         #1;
         if (t0 >= 0) req_valid = '0;
      end
      check("single_pulses", npulse, 1);
      check("single_latency", t1 - t0, LAT + 2);
      check("single_ch", cap_ch, 2);
      check("single_x", cap_x, 1001);
      check("single_y", cap_y, 19'h7FFFF);
      check("single_phase", cap_ph, 5);

      // all four channels busy for 400 cycles
      do_reset();
      res_ready = 1'b1;
      req_valid = 4'hF;
      for (int i = 0; i < 400; i++) begin
         rand_data();
         tick(1);
      end
      req_valid = '0;
      for (int i = 0; i < N; i++) check("fair_share", gcnt[i], 100);
      for (int i = 0; i < 4; i++) check("grant_order", glog[i], eo[i]);
      tick(40);

      // backpressure: credits exhaust at FD grants
      do_reset();
      req_valid = 4'hF;
      rand_data();
      tick(60);
      check("bp_grants", ngrant, 32);
      check("bp_ready_low", req_ready, 0);
      res_ready = 1'b1;
      tick(1);
      res_ready = 1'b0;
      tick(10);
      check("bp_one_more", ngrant, 33);

      // pop in cycle A, then grant + pop together at cred=1 in cycle B
      res_ready = 1'b1;
      tick(2);
      res_ready = 1'b0;
      check("simul_cred", dut.cred, 1);
      check("simul_grants", ngrant, 34);
      tick(10);
      check("simul_after", ngrant, 35);
      req_valid = '0;
      res_ready = 1'b1;
      tick(60);

      // reset with 10 in flight and 5 buffered
      do_reset();
      req_valid = 4'b0001;
      rand_data();
      tick(15);
      req_valid = '0;
      tick(12);
      check("pre_rst_valid", res_valid, 1);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      check("cred_after_rst", dut.cred, 32);
      res_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (res_valid) seen++;
         @(posedge clk);
         #1;
      end
      check("no_stale", seen, 0);

      // random traffic with random consumer stalls
      do_reset();
      budget = 0;
      while (ngrant < 1000 && budget < 20000) begin
         req_valid = N'($urandom());
         rand_data();
         res_ready = ($urandom_range(0, 3) != 0);
         tick(1);
         budget++;
      end
      check("rand_grants", (ngrant >= 1000) ? 1 : 0, 1);
      req_valid = '0;
      res_ready = 1'b1;
      tick(80);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
